// File: rtl/sense_trace_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : sense_trace_recorder
//  Description : Trigger-aligned capture of encoded sensor samples into the
//                trace BRAM write port, with a level arm/done handshake to
//                the readout controller in the other clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module sense_trace_recorder #(
  parameter int DEPTH       = 56,
  parameter int DECIM       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk48m,
  input  logic       rst,
  input  logic       arm,
  input  logic       trig,
  input  logic [7:0] cfg_delay,
  input  logic [6:0] sense_in,
  output logic       we,
  output logic [8:0] waddr,
  output logic [7:0] wdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Ten-bit sample count so that DEPTH=512 is reachable without wrapping.
  localparam logic [9:0] C_DEPTH      = 10'(DEPTH);
  localparam logic [3:0] C_DECIM_LAST = 4'(DECIM - 1);
  // Phase of the decimation counter right after a write.
  localparam logic [3:0] C_DCNT_POST  = (DECIM == 1) ? 4'd0 : 4'd1;

  logic [SYNC_STAGES-1:0] arm_sync_q;
  logic [SYNC_STAGES-1:0] trig_sync_q;
  logic                   trig_q;
  logic                   arm_s;
  logic                   trig_s;
  logic                   trig_e;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [8:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  dly_q, dly_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [9:0]  scnt_q, scnt_d;
  logic        write_now;

  assign arm_s  = arm_sync_q[SYNC_STAGES-1];
  assign trig_s = trig_sync_q[SYNC_STAGES-1];
  assign trig_e = trig_s & ~trig_q;

  // Bring arm and trig into the sample clock domain and keep the delayed trig for edge detection.
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      arm_sync_q  <= '0;
      trig_sync_q <= '0;
      trig_q      <= 1'b0;
    end else begin
      arm_sync_q  <= {arm_sync_q[SYNC_STAGES-2:0], arm};
      trig_sync_q <= {trig_sync_q[SYNC_STAGES-2:0], trig};
      trig_q      <= trig_s;
    end
  end

  // Capture state, counters and registered BRAM/handshake outputs.
  always_ff @(posedge clk48m or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dly_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dly_q   <= dly_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Next-state logic; a write is issued on the same edge that first enters CAPTURE.
  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    scnt_d    = scnt_q;
    write_now = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm_s) begin
          state_d = S_ARMED;
          waddr_d = '0;
          dly_d   = cfg_delay;
          dcnt_d  = '0;
          scnt_d  = '0;
        end
      end
      S_ARMED: begin
        if (!arm_s) begin
          state_d = S_IDLE;
        end else if (trig_e) begin
          if (dly_q == 8'd0) begin
            write_now = 1'b1;
          end else begin
            state_d = S_DELAY;
            cnt_d   = dly_q - 8'd1;
          end
        end
      end
      S_DELAY: begin
        if (!arm_s) begin
          state_d = S_IDLE;
        end else if (cnt_q == 8'd0) begin
          write_now = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_CAPTURE: begin
        if (!arm_s) begin
          state_d = S_IDLE;
        end else if (scnt_q == C_DEPTH) begin
          // Last sample was presented on the previous cycle.
          state_d = S_DONE;
        end else if (dcnt_q == 4'd0) begin
          write_now = 1'b1;
        end else begin
          dcnt_d = (dcnt_q == C_DECIM_LAST) ? 4'd0 : dcnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (!arm_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (write_now) begin
      state_d = S_CAPTURE;
      we_d    = 1'b1;
      waddr_d = scnt_q[8:0];
      wdata_d = {1'b0, sense_in};
      scnt_d  = scnt_q + 10'd1;
      dcnt_d  = C_DCNT_POST;
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_comb begin
    busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sense_trace_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sense_trace_recorder
//  Description : Scoreboard bench for sense_trace_recorder; two instances
//                (DECIM=1 and DECIM=4) share all stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sense_trace_recorder;

  localparam int DEPTH = 56;
  localparam int DEC_A = 1;
  localparam int DEC_B = 4;
  localparam int TABN  = 16384;

  logic       clk48m = 1'b0;
  logic       rst;
  logic       arm;
  logic       trig;
  logic [7:0] cfg_delay;
  logic [6:0] sense_in;

  logic       we_a, busy_a, done_a;
  logic [8:0] waddr_a;
  logic [7:0] wdata_a;
  logic       we_b, busy_b, done_b;
  logic [8:0] waddr_b;
  logic [7:0] wdata_b;

  sense_trace_recorder #(.DEPTH(DEPTH), .DECIM(DEC_A), .SYNC_STAGES(2)) dut_a (
    .clk48m(clk48m), .rst(rst), .arm(arm), .trig(trig), .cfg_delay(cfg_delay),
    .sense_in(sense_in), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a)
  );

  sense_trace_recorder #(.DEPTH(DEPTH), .DECIM(DEC_B), .SYNC_STAGES(2)) dut_b (
    .clk48m(clk48m), .rst(rst), .arm(arm), .trig(trig), .cfg_delay(cfg_delay),
    .sense_in(sense_in), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b)
  );

  always #10 clk48m = ~clk48m;

  // Edge counter: after posedge number n, cyc == n.
  int cyc = 0;
  always @(posedge clk48m) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [6:0] sense_tab [TABN];

  typedef struct {
    int e;
    int a;
    int d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   last_a = -100;
  int   last_b = -100;
  logic pdone_a = 1'b0;
  logic pdone_b = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk48m);
    #1;
  endtask

  // Reference: trigger raised after edge k -> E0=k+1, first write at E0+2+d,
  // then one write every DECIM edges; data is the sensor value sampled on that edge.
  task automatic push_capture(input int k, input int d);
    exp_t x;
    int   first;
    first = k + 3 + d;
    for (int i = 0; i < DEPTH; i++) begin
      x.e = first + i * DEC_A;
      x.a = i;
      x.d = int'(sense_tab[x.e - 1]);
      qa.push_back(x);
      x.e = first + i * DEC_B;
      x.a = i;
      x.d = int'(sense_tab[x.e - 1]);
      qb.push_back(x);
    end
  endtask

  // Arm dropped after edge a: arm_s falls after edge a+2, IDLE at edge a+3.
  task automatic trim_abort(input int a);
    while (qa.size() > 0 && qa[$].e >= a + 3) void'(qa.pop_back());
    while (qb.size() > 0 && qb[$].e >= a + 3) void'(qb.pop_back());
  endtask

  // Drive the sensor from a pre-drawn table so the model knows future values.
  initial begin
    sense_in = '0;
    forever begin
      @(posedge clk48m);
      #1;
      sense_in = sense_tab[cyc % TABN];
    end
  end

  // Monitor: every write is matched against the scoreboard head.
  always @(negedge clk48m) begin
    exp_t x;
    if (!rst) begin
      if (we_a) begin
        if (qa.size() == 0) chk("a_unexpected_we", int'(waddr_a), -1);
        else begin
          x = qa.pop_front();
          chk("a_wr_edge", cyc, x.e);
          chk("a_waddr", int'(waddr_a), x.a);
          chk("a_wdata", int'(wdata_a), x.d);
        end
        last_a = cyc;
      end
      if (done_a && !pdone_a) chk("a_done_rise", cyc, last_a + 1);
      if (we_b) begin
        if (qb.size() == 0) chk("b_unexpected_we", int'(waddr_b), -1);
        else begin
          x = qb.pop_front();
          chk("b_wr_edge", cyc, x.e);
          chk("b_waddr", int'(waddr_b), x.a);
          chk("b_wdata", int'(wdata_b), x.d);
        end
        last_b = cyc;
      end
      if (done_b && !pdone_b) chk("b_done_rise", cyc, last_b + 1);
    end
    pdone_a = done_a;
    pdone_b = done_b;
  end

  task automatic do_arm(input int d);
    cfg_delay = 8'(d);
    arm = 1'b1;
    repeat (5) tick();
    chk("armed_busy_a", int'(busy_a), 1);
    chk("armed_busy_b", int'(busy_b), 1);
  endtask

  task automatic trigger(input int w);
    int k;
    k = cyc;
    trig = 1'b1;
    push_capture(k, int'(cfg_delay));
    repeat (w) tick();
    trig = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!(qa.size() == 0 && qb.size() == 0 && done_a && done_b) && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_pending_a"}, qa.size(), 0);
    chk({nm, "_pending_b"}, qb.size(), 0);
    chk({nm, "_done_a"}, int'(done_a), 1);
    chk({nm, "_done_b"}, int'(done_b), 1);
    chk({nm, "_busy_a"}, int'(busy_a), 0);
    chk({nm, "_busy_b"}, int'(busy_b), 0);
    chk({nm, "_last_waddr_a"}, int'(waddr_a), DEPTH - 1);
    chk({nm, "_last_waddr_b"}, int'(waddr_b), DEPTH - 1);
  endtask

  task automatic disarm(input string nm);
    arm = 1'b0;
    repeat (4) tick();
    chk({nm, "_idle_done_a"}, int'(done_a), 0);
    chk({nm, "_idle_done_b"}, int'(done_b), 0);
    chk({nm, "_idle_busy_a"}, int'(busy_a), 0);
    chk({nm, "_idle_busy_b"}, int'(busy_b), 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < TABN; i++) sense_tab[i] = 7'($urandom);
    rst = 1'b1;
    arm = 1'b0;
    trig = 1'b0;
    cfg_delay = '0;
    repeat (3) tick();
    chk("rst_we_a", int'(we_a), 0);
    chk("rst_waddr_a", int'(waddr_a), 0);
    chk("rst_wdata_a", int'(wdata_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_we_b", int'(we_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_done_b", int'(done_b), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Triggers while idle must be ignored.
    for (int i = 0; i < 2; i++) begin
      trig = 1'b1;
      repeat (3) tick();
      trig = 1'b0;
      repeat (3) tick();
    end
    repeat (5) tick();
    chk("idle_trig_busy_a", int'(busy_a), 0);
    chk("idle_trig_busy_b", int'(busy_b), 0);

    // Basic capture, no delay.
    do_arm(0);
    trigger(8);
    wait_done("basic");
    disarm("basic");

    // Delayed capture.
    do_arm(10);
    trigger(3);
    wait_done("delay");
    disarm("delay");

    // trig already high when arming is not a trigger.
    trig = 1'b1;
    repeat (4) tick();
    do_arm(int'($urandom_range(0, 20)));
    repeat (10) tick();
    chk("held_trig_busy_a", int'(busy_a), 1);
    chk("held_trig_nowrite", int'(we_a) + int'(we_b), 0);
    trig = 1'b0;
    repeat (4) tick();
    trigger(2);
    wait_done("held");
    disarm("held");

    // A second trigger edge during the capture is ignored.
    do_arm(int'($urandom_range(0, 40)));
    trigger(2);
    repeat (20) tick();
    trig = 1'b1;
    repeat (2) tick();
    trig = 1'b0;
    wait_done("retrig");
    disarm("retrig");

    // Abort after 20 writes of the DECIM=1 instance.
    do_arm(0);
    k = cyc;
    trigger(8);
    while (cyc < k + 3 + 19) tick();
    arm = 1'b0;
    trim_abort(cyc);
    repeat (6) tick();
    chk("abort_pending_a", qa.size(), 0);
    chk("abort_pending_b", qb.size(), 0);
    chk("abort_busy_a", int'(busy_a), 0);
    chk("abort_busy_b", int'(busy_b), 0);
    chk("abort_done_a", int'(done_a), 0);
    chk("abort_done_b", int'(done_b), 0);

    // Back-to-back captures, including the maximum delay.
    for (int i = 0; i < 3; i++) begin
      do_arm((i == 2) ? 255 : int'($urandom_range(0, 40)));
      trigger(int'($urandom_range(1, 8)));
      wait_done("b2b");
      disarm("b2b");
    end

    // Asynchronous reset in the middle of a capture.
    do_arm(5);
    trigger(3);
    repeat (25) tick();
    #4;
    rst = 1'b1;
    #1;
    chk("mid_rst_we_a", int'(we_a), 0);
    chk("mid_rst_waddr_a", int'(waddr_a), 0);
    chk("mid_rst_busy_a", int'(busy_a), 0);
    chk("mid_rst_done_a", int'(done_a), 0);
    chk("mid_rst_we_b", int'(we_b), 0);
    chk("mid_rst_waddr_b", int'(waddr_b), 0);
    chk("mid_rst_busy_b", int'(busy_b), 0);
    chk("mid_rst_done_b", int'(done_b), 0);
    qa.delete();
    qb.delete();
    arm = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    do_arm(int'($urandom_range(0, 15)));
    trigger(4);
    wait_done("post_rst");
    disarm("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sense_trace_recorder.md
# sense_trace_recorder

Capture engine on the 48 MHz sensor clock. It records encoded sensor samples into the trace BRAM write port during a trigger-aligned window, normally the start of the last AES round. The UART readout logic in the 12 MHz domain drains the same BRAM through its read port. This block owns the write side. It handshakes with the readout controller through a level-based arm/done pair that crosses clock domains.

## Interface
Parameters:
- DEPTH, 56: samples written per capture (1..512).
- DECIM, 1: write one sample every DECIM clk48m cycles (1..16).
- SYNC_STAGES, 2: synchronizer depth for arm and trig (≥2).

Ports:
- clk48m  in  1  sample clock; sensor and BRAM write clock.
- rst  in  1  reset rst, asynchronous, active-high; clock clk48m.
- arm  in  1  level from the clk domain; high means capture requested. Held until done is seen.
- trig  in  1  aes_lastround from the clk domain. Trigger is its rising edge.
- cfg_delay  in  8  cycles between the trigger edge and the first write. Sampled on arm acceptance.
- sense_in  in  7  encoded sensor value from the decoder (clk48m domain).
- we  out  1  BRAM write enable; also drives WCLKE.
- waddr  out  9  BRAM write address.
- wdata  out  8  {1'b0, sense_in}, registered.
- busy  out  1  high in ARMED, DELAY and CAPTURE.
- done  out  1  high in DONE. The clk domain synchronizes it.

## Operation
- Synchronization: arm and trig each pass through SYNC_STAGES flops, giving arm_s and trig_s. trig_q is trig_s delayed one cycle. Trigger edge: trig_e = trig_s & ~trig_q.
- Outputs are all registered.
- States:
  - IDLE: we=0, done=0, busy=0. arm_s=1 → ARMED; waddr←0, dly←cfg_delay, dcnt←0.
  - ARMED: wait for trig_e.
    - trig_e with dly=0 → CAPTURE.
    - trig_e with dly≠0 → DELAY, cnt←dly-1.
    - A trig level already high at arming is not a trigger; only a new edge counts.
  - DELAY: cnt decrements each cycle. cnt=0 → CAPTURE.
  - CAPTURE: dcnt counts 0..DECIM-1.
    - On dcnt=0: we=1, wdata←{0,sense_in}, and waddr becomes the sample index, starting at 0.
    - After the write at waddr=DEPTH-1 → DONE, we=0.
    - waddr never exceeds DEPTH-1, with no wrap.
  - DONE: done=1, we=0, waddr holds DEPTH-1. arm_s=0 → IDLE.
- Abort: arm_s falling in ARMED, DELAY or CAPTURE → IDLE next cycle, we=0. Partial data is left in the BRAM.
- trig_e outside ARMED is ignored, including re-triggers during DELAY or CAPTURE.
- Arithmetic: sample counter is 10 bits so DEPTH=512 terminates correctly. Delay counter is 8 bits.

## Timing
- Reset values: we=0, waddr=0, wdata=0, busy=0, done=0, state=IDLE, all synchronizer flops 0.
- Clock edge naming: E0 is the first clk48m edge at which trig=1 enters sync stage 1. With SYNC_STAGES=2, trig_e is high in the cycle after E1.
- Latency from trigger:
  - cfg_delay=0: state=CAPTURE and the first we=1 (waddr=0) take effect at E2. The BRAM captures that sample at E3.
  - cfg_delay=D: the first write takes effect at E2+D.
- Write spacing: consecutive writes are exactly DECIM cycles apart. A capture spans (DEPTH-1)·DECIM+1 cycles.
- With DECIM=1, we stays high for DEPTH consecutive cycles.
- done rises one cycle after the last we=1 cycle.
- Arm latency: IDLE→ARMED occurs SYNC_STAGES+1 edges after arm rises. DONE→IDLE follows the same latency after arm falls.
- Reset mid-capture: outputs return to reset values asynchronously, with no further writes.

## Test plan
- Basic: DEPTH=56, DECIM=1, cfg_delay=0. Raise arm, pulse trig high for 8 cycles, ramp sense_in 0,1,2…
  → exactly 56 we cycles, waddr 0..55, wdata = 0x00..0x37 with a 2-edge offset. Then done=1 and busy=0.
- Delay/decimation: cfg_delay=10, DECIM=4 → the first we occurs 12 edges after E0. There are 56 writes at 4-cycle spacing and the last waddr=55.
- Trigger filtering:
  - trig pulses while IDLE → no we, stays IDLE.
  - trig already high at arming → no capture until trig falls and rises again.
  - Second trig edge during CAPTURE → exactly 56 writes.
- Abort: drop arm after 20 writes → we=0 within SYNC_STAGES+1 edges, IDLE, done never asserted.
- Handshake cycle: after done, drop arm → IDLE, done=0. Re-arm and trigger → a new capture starting at waddr=0. Run three back-to-back captures.
- Reset: assert rst asynchronously mid-CAPTURE → we, waddr, busy and done are 0 immediately. After release the block arms and captures normally.
